// File: rtl/bot_upd_ctrl_pkg.sv
// Shared types and constants for the rojobot update handshake controller.
`default_nettype none

package bot_upd_ctrl_pkg;

  localparam int BOT_INFO_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PEND = 2'b01,
    ST_HOLD = 2'b10
  } bot_state_e;

endpackage

`default_nettype wire

// File: rtl/bot_upd_ctrl.sv
// Rojobot-to-CPU update handshake: snapshot, sticky flag, overrun/timeout status,
// and the registered motor-control byte toward the bot.
`default_nettype none

module bot_upd_ctrl
  import bot_upd_ctrl_pkg::*;
#(
  parameter int TO_W  = 20,
  parameter int OVR_W = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  bot_upd_req,
  input  logic [BOT_INFO_W-1:0] bot_info_in,
  input  logic                  int_ack,
  input  logic                  mot_wr,
  input  logic [7:0]            mot_wdata,
  input  logic                  ctl_en,
  input  logic                  stat_clr,
  output logic [BOT_INFO_W-1:0] bot_info_out,
  output logic                  upd_flag,
  output logic [7:0]            mot_ctl_out,
  output logic [OVR_W-1:0]      ovr_cnt,
  output logic                  timeout_sticky
);

  // Timer value on the cycle whose increment would reach 2**TO_W-1.
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  bot_state_e      state;
  logic            pend_req;
  logic [TO_W-1:0] timer;
  logic [7:0]      mot_reg;

  logic in_pend;
  logic ovr_evt;
  logic to_evt;

  // Ack takes priority over both a new request and a timeout.
  assign in_pend = (state == ST_PEND);
  assign ovr_evt = in_pend && bot_upd_req && !int_ack;
  assign to_evt  = in_pend && !bot_upd_req && !int_ack && (timer == TO_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      upd_flag <= 1'b0;
      pend_req <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bot_upd_req) begin
            state    <= ST_PEND;
            upd_flag <= 1'b1;
          end
        end
        ST_PEND: begin
          if (int_ack) begin
            state    <= ST_HOLD;
            upd_flag <= 1'b0;
            pend_req <= bot_upd_req;
          end else if (to_evt) begin
            state    <= ST_IDLE;
            upd_flag <= 1'b0;
          end
        end
        ST_HOLD: begin
          pend_req <= 1'b0;
          if (pend_req || bot_upd_req) begin
            state    <= ST_PEND;
            upd_flag <= 1'b1;
          end else begin
            state    <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          upd_flag <= 1'b0;
          pend_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer <= '0;
    end else if (in_pend && !int_ack && !bot_upd_req && !to_evt) begin
      timer <= timer + 1'b1;
    end else begin
      timer <= '0;
    end
  end

  // Latest request always wins, whatever state it lands in.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bot_info_out <= '0;
    end else if (bot_upd_req) begin
      bot_info_out <= bot_info_in;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovr_cnt        <= '0;
      timeout_sticky <= 1'b0;
    end else if (stat_clr) begin
      ovr_cnt        <= '0;
      timeout_sticky <= 1'b0;
    end else begin
      if (ovr_evt && (ovr_cnt != {OVR_W{1'b1}})) begin
        ovr_cnt <= ovr_cnt + 1'b1;
      end
      if (to_evt) begin
        timeout_sticky <= 1'b1;
      end
    end
  end

  // Write data is forwarded so the bot sees a new byte one cycle after the strobe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mot_reg     <= 8'h00;
      mot_ctl_out <= 8'h00;
    end else begin
      if (mot_wr) begin
        mot_reg <= mot_wdata;
      end
      mot_ctl_out <= ctl_en ? (mot_wr ? mot_wdata : mot_reg) : 8'h00;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bot_upd_ctrl.sv
// Directed bench for bot_upd_ctrl with a cycle-level behavioural model and literal pins.
`default_nettype none

module tb_bot_upd_ctrl;

  localparam int TO_W  = 4;
  localparam int OVR_W = 8;
  localparam int TO_LIMIT = (1 << TO_W) - 1;
  localparam int OVR_MAX  = (1 << OVR_W) - 1;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        bot_upd_req = 1'b0;
  logic [31:0] bot_info_in = 32'h0;
  logic        int_ack = 1'b0;
  logic        mot_wr = 1'b0;
  logic [7:0]  mot_wdata = 8'h0;
  logic        ctl_en = 1'b0;
  logic        stat_clr = 1'b0;
  logic [31:0] bot_info_out;
  logic        upd_flag;
  logic [7:0]  mot_ctl_out;
  logic [OVR_W-1:0] ovr_cnt;
  logic        timeout_sticky;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  bot_upd_ctrl #(.TO_W(TO_W), .OVR_W(OVR_W)) dut (
    .clk(clk), .resetn(resetn), .bot_upd_req(bot_upd_req), .bot_info_in(bot_info_in),
    .int_ack(int_ack), .mot_wr(mot_wr), .mot_wdata(mot_wdata), .ctl_en(ctl_en),
    .stat_clr(stat_clr), .bot_info_out(bot_info_out), .upd_flag(upd_flag),
    .mot_ctl_out(mot_ctl_out), .ovr_cnt(ovr_cnt), .timeout_sticky(timeout_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: flag visible to CPU, how long it has been up, a one-cycle
  // quiet gap after each ack, and a request remembered across that gap.
  bit        m_flag, m_gap, m_queued;
  int        m_age, m_ovr;
  bit        m_to;
  bit [31:0] m_info;
  bit [7:0]  m_motreg, m_mot;

  always @(posedge clk or negedge resetn) begin
    bit overrun_now, timeout_now;
    if (!resetn) begin
      m_flag = 0; m_gap = 0; m_queued = 0; m_age = 0; m_ovr = 0; m_to = 0;
      m_info = 0; m_motreg = 0; m_mot = 0;
    end else begin
      overrun_now = 0; timeout_now = 0;
      if (mot_wr) m_motreg = mot_wdata;
      m_mot = ctl_en ? m_motreg : 8'h00;
      if (bot_upd_req) m_info = bot_info_in;
      if (m_flag) begin
        if (int_ack) begin
          m_flag = 0; m_gap = 1; m_queued = bot_upd_req;
        end else if (bot_upd_req) begin
          overrun_now = 1; m_age = 0;
        end else begin
          m_age++;
          if (m_age == TO_LIMIT) begin timeout_now = 1; m_flag = 0; m_age = 0; end
        end
      end else if (m_gap) begin
        m_gap = 0;
        if (m_queued || bot_upd_req) begin m_flag = 1; m_age = 0; end
        m_queued = 0;
      end else if (bot_upd_req) begin
        m_flag = 1; m_age = 0;
      end
      if (stat_clr) begin
        m_ovr = 0; m_to = 0;
      end else begin
        if (overrun_now && m_ovr < OVR_MAX) m_ovr++;
        if (timeout_now) m_to = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_upd_flag", {31'b0, upd_flag}, {31'b0, m_flag});
      chk("model_bot_info", bot_info_out, m_info);
      chk("model_ovr_cnt", {24'b0, ovr_cnt}, m_ovr);
      chk("model_timeout", {31'b0, timeout_sticky}, {31'b0, m_to});
      chk("model_mot_ctl", {24'b0, mot_ctl_out}, {24'b0, m_mot});
    end
  end

  task automatic req_pulse(input logic [31:0] info);
    bot_upd_req = 1'b1; bot_info_in = info;
    @(negedge clk);
    bot_upd_req = 1'b0;
  endtask

  task automatic ack_pulse();
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
  endtask

  initial begin
    int hi_cycles;
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi_cycles;
    ctl_en = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_flag", {31'b0, upd_flag}, 32'd0);
    chk("reset_info", bot_info_out, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // 1: first capture
    req_pulse(32'h12345678);
    chk("t1_flag", {31'b0, upd_flag}, 32'd1);
    chk("t1_info", bot_info_out, 32'h12345678);

    // 2: three overruns, then ack
    req_pulse(32'hAAAA0001);
    req_pulse(32'hBBBB0002);
    req_pulse(32'hCCCC0003);
    chk("t2_ovr", {24'b0, ovr_cnt}, 32'd3);
    chk("t2_info", bot_info_out, 32'hCCCC0003);
    ack_pulse();
    chk("t2_flag_gap", {31'b0, upd_flag}, 32'd0);
    @(negedge clk);
    chk("t2_flag_idle", {31'b0, upd_flag}, 32'd0);
    ack_pulse();  // ack in idle ignored
    chk("idle_ack_flag", {31'b0, upd_flag}, 32'd0);

    // 3: ack and req together
    req_pulse(32'h0000_1111);
    int_ack = 1'b1; bot_upd_req = 1'b1; bot_info_in = 32'hCAFE0001;
    @(negedge clk);
    int_ack = 1'b0; bot_upd_req = 1'b0;
    chk("t3_flag_gap", {31'b0, upd_flag}, 32'd0);
    @(negedge clk);
    chk("t3_flag_back", {31'b0, upd_flag}, 32'd1);
    chk("t3_info", bot_info_out, 32'hCAFE0001);
    chk("t3_ovr", {24'b0, ovr_cnt}, 32'd3);
    // req during the quiet gap also re-raises the flag
    ack_pulse();
    req_pulse(32'hD00D0004);
    chk("hold_req_flag", {31'b0, upd_flag}, 32'd1);
    chk("hold_req_info", bot_info_out, 32'hD00D0004);
    ack_pulse();
    repeat (2) @(negedge clk);

    // 4: timeout after 15 cycles of pending
    req_pulse(32'h7E570005);
    hi_cycles = 0;
    for (int i = 0; i < 40 && upd_flag; i++) begin
      hi_cycles++;
      @(negedge clk);
    end
    chk("t4_hi_cycles", hi_cycles, 32'd15);
    chk("t4_timeout", {31'b0, timeout_sticky}, 32'd1);
    chk("t4_info_kept", bot_info_out, 32'h7E570005);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    chk("t4_clr_to", {31'b0, timeout_sticky}, 32'd0);
    chk("t4_clr_ovr", {24'b0, ovr_cnt}, 32'd0);

    // overrun saturation, then clear coincident with overrun
    req_pulse(32'h1);
    for (int i = 0; i < OVR_MAX + 5; i++) req_pulse(32'h100 + i);
    chk("sat_ovr", {24'b0, ovr_cnt}, OVR_MAX);
    stat_clr = 1'b1; bot_upd_req = 1'b1; bot_info_in = 32'h5A5A5A5A;
    @(negedge clk);
    stat_clr = 1'b0; bot_upd_req = 1'b0;
    chk("clr_wins_ovr", {24'b0, ovr_cnt}, 32'd0);
    ack_pulse();
    repeat (2) @(negedge clk);

    // 5: motor control
    mot_wr = 1'b1; mot_wdata = 8'h33;
    @(negedge clk);
    mot_wr = 1'b0;
    chk("t5_mot_on", {24'b0, mot_ctl_out}, 32'h33);
    ctl_en = 1'b0;
    @(negedge clk);
    chk("t5_mot_frozen", {24'b0, mot_ctl_out}, 32'h00);
    ctl_en = 1'b1;
    @(negedge clk);
    chk("t5_mot_back", {24'b0, mot_ctl_out}, 32'h33);

    // 6: async reset mid-pending
    req_pulse(32'hBEEF0006);
    chk("t6_pending", {31'b0, upd_flag}, 32'd1);
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("t6_rst_flag", {31'b0, upd_flag}, 32'd0);
    chk("t6_rst_info", bot_info_out, 32'd0);
    chk("t6_rst_mot", {24'b0, mot_ctl_out}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    ack_pulse();
    chk("t6_ack_ignored", {31'b0, upd_flag}, 32'd0);
    repeat (2) @(negedge clk);
    chk("t6_info_zero", bot_info_out, 32'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
